// File: rtl/programmable_clock_divider_pkg.sv
// rtl/programmable_clock_divider_pkg.sv - shared mode encodings and reset divisor
package programmable_clock_divider_pkg;

  typedef enum logic {
    MODE_PULSE  = 1'b0,
    MODE_SQUARE = 1'b1
  } mode_e;

  localparam int DIV_RESET_DEFAULT = 50;

endpackage

// File: rtl/programmable_clock_divider_if.sv
// rtl/programmable_clock_divider_if.sv - control and output bundle of the clock divider
interface programmable_clock_divider_if #(
  parameter int WIDTH = 16
);
  logic             en;
  logic             div_load;
  logic [WIDTH-1:0] div_value;
  logic             mode;
  logic             clk_div;
  logic             tick;
  logic             pending;
  logic             err;

  modport master (
    output en, div_load, div_value, mode,
    input  clk_div, tick, pending, err
  );

  modport slave (
    input  en, div_load, div_value, mode,
    output clk_div, tick, pending, err
  );
endinterface

// File: rtl/div_phase_counter.sv
// rtl/div_phase_counter.sv - phase counter 0..N-1 with terminal compare and wrap detect
module div_phase_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] n_active,
  output logic [WIDTH-1:0] p_inc,
  output logic             wrap
);

  logic [WIDTH-1:0] p;

  // Terminal compare against N-1 so N = 2^WIDTH-1 never needs a wider counter
  assign p_inc = p + WIDTH'(1);
  assign wrap  = en && (p == (n_active - WIDTH'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p <= '0;
    end else if (en) begin
      p <= wrap ? '0 : p_inc;
    end
  end

endmodule

// File: rtl/programmable_clock_divider.sv
// rtl/programmable_clock_divider.sv - divider top: shadow divisor/mode, apply at wrap, output registers
module programmable_clock_divider
  import programmable_clock_divider_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DIV_RESET = DIV_RESET_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst_n,
  programmable_clock_divider_if.slave    bus
);

  localparam logic [WIDTH-1:0] N_RESET = WIDTH'(DIV_RESET);

  logic [WIDTH-1:0] n_active;
  logic [WIDTH-1:0] n_shadow;
  logic [WIDTH-1:0] p_inc;
  mode_e            mode_active;
  mode_e            mode_shadow;
  mode_e            mode_in;
  logic             pending_q;
  logic             err_q;
  logic             tick_q;
  logic             clk_div_q;
  logic             wrap;
  logic             load_legal;
  logic             load_illegal;

  assign mode_in      = mode_e'(bus.mode);
  assign load_legal   = bus.div_load && (bus.div_value >= WIDTH'(2));
  assign load_illegal = bus.div_load && !load_legal;

  div_phase_counter #(.WIDTH(WIDTH)) u_phase (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (bus.en),
    .n_active (n_active),
    .p_inc    (p_inc),
    .wrap     (wrap)
  );

  // Divisor and mode only change at a wrap, so a period is never cut or stretched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_active    <= N_RESET;
      n_shadow    <= N_RESET;
      mode_active <= MODE_SQUARE;
      mode_shadow <= MODE_SQUARE;
      pending_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (wrap) begin
        pending_q <= 1'b0;
        if (load_legal) begin
          n_active    <= bus.div_value;
          mode_active <= mode_in;
          n_shadow    <= bus.div_value;
          mode_shadow <= mode_in;
        end else if (pending_q) begin
          n_active    <= n_shadow;
          mode_active <= mode_shadow;
        end
      end else if (load_legal) begin
        n_shadow    <= bus.div_value;
        mode_shadow <= mode_in;
        pending_q   <= 1'b1;
      end

      if (load_legal) begin
        err_q <= 1'b0;
      end else if (load_illegal) begin
        err_q <= 1'b1;
      end
    end
  end

  // A wrap starts the high phase in both modes; pulse mode drops with tick when disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q    <= 1'b0;
      clk_div_q <= 1'b0;
    end else begin
      tick_q <= wrap;
      if (wrap) begin
        clk_div_q <= 1'b1;
      end else if (bus.en) begin
        clk_div_q <= (mode_active == MODE_SQUARE) && (p_inc < (n_active >> 1));
      end else if (mode_active == MODE_PULSE) begin
        clk_div_q <= 1'b0;
      end
    end
  end

  assign bus.tick    = tick_q;
  assign bus.clk_div = clk_div_q;
  assign bus.pending = pending_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_programmable_clock_divider.sv
// tb/tb_programmable_clock_divider.sv - self-checking bench for programmable_clock_divider
module tb_programmable_clock_divider;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [3:0] obs;

  always #5 clk = ~clk;

  programmable_clock_divider_if #(.WIDTH(16)) bus ();
  programmable_clock_divider_if #(.WIDTH(4))  sbus ();

  programmable_clock_divider #(.WIDTH(16), .DIV_RESET(50)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  programmable_clock_divider #(.WIDTH(4), .DIV_RESET(15)) u_small (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sbus)
  );

  // Reference: phase as a modulo-N integer; shadow applied when the phase returns to 0
  int m_n, m_sn, m_pos;
  bit m_mode, m_smode, m_pend, m_err, m_tick, m_clk;

  task automatic model_reset();
    m_n = 50; m_sn = 50; m_pos = 0;
    m_mode = 1'b1; m_smode = 1'b1;
    m_pend = 1'b0; m_err = 1'b0; m_tick = 1'b0; m_clk = 1'b0;
  endtask

  task automatic model_edge(input bit e, input bit l, input int v, input bit m);
    bit legal;
    bit wrapped;
    legal = l && (v >= 2);
    wrapped = 1'b0;
    if (e) begin
      m_pos = (m_pos + 1) % m_n;
      wrapped = (m_pos == 0);
    end
    if (wrapped) begin
      if (legal) begin
        m_n = v; m_mode = m; m_sn = v; m_smode = m;
      end else if (m_pend) begin
        m_n = m_sn; m_mode = m_smode;
      end
      m_pend = 1'b0;
    end else if (legal) begin
      m_sn = v; m_smode = m; m_pend = 1'b1;
    end
    if (legal) m_err = 1'b0;
    else if (l) m_err = 1'b1;
    m_tick = wrapped;
    if (e) m_clk = m_mode ? (m_pos < m_n / 2) : wrapped;
    else if (!m_mode) m_clk = 1'b0;
  endtask

  task automatic drive(input bit e, input bit l, input int v, input bit m);
    bus.en = e; bus.div_load = l; bus.div_value = 16'(v); bus.mode = m;
    @(posedge clk); #1;
    model_edge(e, l, v, m);
    obs = {bus.clk_div, bus.tick, bus.pending, bus.err};
  endtask

  task automatic do_reset();
    bus.en = 1'b0; bus.div_load = 1'b0; bus.div_value = '0; bus.mode = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.clk_div, bus.tick, bus.pending, bus.err, sbus.clk_div, sbus.tick} !== 6'b0) begin
      failures++;
      $display("FAIL reset_async got=%b exp=000000",
               {bus.clk_div, bus.tick, bus.pending, bus.err, sbus.clk_div, sbus.tick});
    end
    drive(1'b1, 1'b0, 0, 1'b1);
    checks++;
    if (obs !== 4'b0000) begin
      failures++;
      $display("FAIL reset_held got=%b exp=0000", obs);
    end
    rst_n = 1'b1;
    model_reset();
    drive(1'b0, 1'b0, 0, 1'b1);
    checks++;
    if (obs !== 4'b0000) begin
      failures++;
      $display("FAIL reset_idle_en0 got=%b exp=0000", obs);
    end
    drive(1'b1, 1'b0, 0, 1'b1);
    checks++;
    if (obs !== 4'b1000) begin
      failures++;
      $display("FAIL reset_first_edge got=%b exp=1000", obs);
    end
  endtask

  task automatic test_default_square();
    logic [3:0] exp;
    do_reset();
    for (int k = 1; k <= 150; k++) begin
      drive(1'b1, 1'b0, 0, k[0]);
      exp = {((k % 50) < 25), (k % 50 == 0), 2'b00};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL default_square k=%0d got=%b exp=%b", k, obs, exp);
      end
    end
  endtask

  task automatic test_apply(input int n, input bit m);
    int cnt;
    bit seen;
    logic [2:0] exp;
    do_reset();
    drive(1'b1, 1'b1, n, m);
    checks++;
    if (obs[1] !== 1'b1) begin
      failures++;
      $display("FAIL apply_pending n=%0d got=%b exp=1", n, obs[1]);
    end
    cnt = 1;
    seen = 1'b0;
    while (!seen && cnt < 60) begin
      drive(1'b1, 1'b0, 0, ~m);
      cnt++;
      seen = obs[2];
    end
    checks++;
    if (!seen || cnt != 50) begin
      failures++;
      $display("FAIL apply_first_tick n=%0d got_edge=%0d seen=%0d exp_edge=50", n, cnt, seen);
    end
    for (int i = 0; i < 3 * n; i++) begin
      if (i > 0) drive(1'b1, 1'b0, 0, ~m);
      exp[1] = (i % n == 0);
      exp[2] = m ? ((i % n) < n / 2) : exp[1];
      exp[0] = 1'b0;
      checks++;
      if (obs[3:1] !== exp) begin
        failures++;
        $display("FAIL apply n=%0d mode=%0d i=%0d got=%b exp=%b", n, m, i, obs[3:1], exp);
      end
    end
  endtask

  task automatic test_midperiod_load();
    logic [2:0] exp;
    do_reset();
    for (int k = 1; k <= 75; k++) begin
      drive(1'b1, (k == 21), 10, 1'b1);
      exp[2] = (k < 50) ? ((k % 50) < 25) : (((k - 50) % 10) < 5);
      exp[1] = (k == 50) || (k == 60) || (k == 70);
      exp[0] = (k >= 21) && (k < 50);
      checks++;
      if (obs[3:1] !== exp) begin
        failures++;
        $display("FAIL midperiod_load k=%0d got=%b exp=%b", k, obs[3:1], exp);
      end
    end
  endtask

  task automatic test_err();
    logic [2:0] exp;
    int v;
    do_reset();
    for (int k = 1; k <= 120; k++) begin
      v = (k == 1) ? 1 : ((k == 2) ? 0 : 8);
      drive(1'b1, (k == 1) || (k == 2) || (k == 60), v, 1'b1);
      exp[2] = (k == 50) || (k == 100) || (k == 108) || (k == 116);
      exp[1] = (k >= 60) && (k < 100);
      exp[0] = (k < 60);
      checks++;
      if (obs[2:0] !== exp) begin
        failures++;
        $display("FAIL err_flag k=%0d got=%b exp=%b", k, obs[2:0], exp);
      end
    end
  endtask

  task automatic test_enable_hold(input int stop);
    bit hold_clk;
    int rem;
    logic [1:0] exp;
    do_reset();
    for (int k = 1; k <= stop; k++) drive(1'b1, 1'b0, 0, 1'b1);
    hold_clk = ((stop % 50) < 25);
    for (int k = 0; k < 13; k++) begin
      drive(1'b0, 1'b0, 0, 1'b0);
      checks++;
      if (obs[3:2] !== {hold_clk, 1'b0}) begin
        failures++;
        $display("FAIL enable_hold stop=%0d k=%0d got=%b exp=%b", stop, k, obs[3:2], {hold_clk, 1'b0});
      end
    end
    rem = 50 - (stop % 50);
    for (int j = 1; j <= rem + 5; j++) begin
      drive(1'b1, 1'b0, 0, 1'b1);
      exp = {(((stop + j) % 50) < 25), (j == rem)};
      checks++;
      if (obs[3:2] !== exp) begin
        failures++;
        $display("FAIL enable_resume stop=%0d j=%0d got=%b exp=%b", stop, j, obs[3:2], exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 1; k <= 10; k++) drive(1'b1, (k == 5), 10, 1'b1);
    checks++;
    if (obs[3:1] !== 3'b101) begin
      failures++;
      $display("FAIL reset_mid_pre got=%b exp=101", obs[3:1]);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.clk_div, bus.tick, bus.pending, bus.err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_mid_async got=%b exp=0000", {bus.clk_div, bus.tick, bus.pending, bus.err});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int k = 1; k <= 60; k++) begin
      drive(1'b1, 1'b0, 0, 1'b1);
      checks++;
      if (obs[2:1] !== {(k == 50), 1'b0}) begin
        failures++;
        $display("FAIL reset_mid_after k=%0d got=%b exp=%b", k, obs[2:1], {(k == 50), 1'b0});
      end
    end
  endtask

  task automatic test_max_width();
    logic [1:0] exp;
    do_reset();
    for (int k = 1; k <= 45; k++) begin
      drive(1'b1, 1'b0, 0, 1'b1);
      exp = {((k % 15) < 7), (k % 15 == 0)};
      checks++;
      if ({sbus.clk_div, sbus.tick} !== exp) begin
        failures++;
        $display("FAIL max_width k=%0d got=%b exp=%b", k, {sbus.clk_div, sbus.tick}, exp);
      end
    end
  endtask

  task automatic test_random();
    bit e, l, m;
    int v;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      e = ($urandom_range(0, 99) < 88);
      l = ($urandom_range(0, 99) < 4);
      v = $urandom_range(0, 12);
      m = 1'($urandom_range(0, 1));
      drive(e, l, v, m);
      checks++;
      if (obs !== {m_clk, m_tick, m_pend, m_err}) begin
        failures++;
        $display("FAIL random k=%0d got=%b exp=%b", k, obs, {m_clk, m_tick, m_pend, m_err});
      end
    end
  endtask

  initial begin
    sbus.en = 1'b1; sbus.div_load = 1'b0; sbus.div_value = '0; sbus.mode = 1'b1;
    bus.en = 1'b0; bus.div_load = 1'b0; bus.div_value = '0; bus.mode = 1'b1;
    model_reset();
    test_reset();
    test_default_square();
    test_apply(7, 1'b1);
    test_apply(2, 1'b1);
    test_apply(2, 1'b0);
    test_apply(13, 1'b0);
    test_midperiod_load();
    test_err();
    test_enable_hold(30);
    test_enable_hold(10);
    test_enable_hold(50);
    test_reset_mid();
    test_max_width();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/programmable_clock_divider.md
PROGRAMMABLE_CLOCK_DIVIDER -- requirements
Module: programmable_clock_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the counter and divisor width in bits.
REQ-002 The block SHALL have parameter DIV_RESET, default 50, giving the divisor N in force after reset; legal range 2..2^WIDTH-1.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset:
- CLK  in  1  sole clock; all state updates on its rising edge.
- RST_N  in  1  asynchronous active-low reset.
REQ-004 The block SHALL have these further ports:
- en  in  1  count enable.
- div_load  in  1  one-cycle strobe; captures div_value.
- div_value  in  WIDTH  requested divisor N.
- mode  in  1  0 = pulse mode, 1 = square mode.
- clk_div  out  1  divided output.
- tick  out  1  one-cycle pulse per period.
- pending  out  1  captured divisor/mode not yet applied.
- err  out  1  sticky flag: illegal divisor request.

Function
REQ-005 The block SHALL hold a phase counter p in 0..N-1; p advances by 1 on each CLK edge with en=1 and wraps from N-1 to 0.
REQ-006 With en=0, p, clk_div and err SHALL hold, and tick SHALL be 0 from the next edge.
REQ-007 tick SHALL be registered and SHALL be 1 for exactly the cycle following an edge on which p wrapped to 0; the first tick after reset SHALL follow the N-th enabled edge.
REQ-008 In square mode, clk_div SHALL be registered and equal to (p_new < floor(N/2)) after each enabled edge, giving floor(N/2) cycles high and ceil(N/2) cycles low per period, with the rising edge coincident with tick.
REQ-009 Because p=0 at reset, the first high phase in square mode SHALL last floor(N/2)-1 cycles; later periods SHALL be exact.
REQ-010 In pulse mode, clk_div SHALL equal tick.
REQ-011 On div_load=1 with div_value>=2, the block SHALL capture div_value and mode into shadow registers and set pending.
REQ-012 On div_load=1 with div_value<2, the block SHALL leave the shadow registers and pending unchanged and set err; err SHALL clear only on a later legal div_load.
REQ-013 Shadow divisor and mode SHALL become active only on an edge where p wraps to 0, and pending SHALL clear on that edge; period length and duty cycle SHALL never change mid-period.
REQ-014 If div_load coincides with a wrapping edge, the newly presented value SHALL take effect at that wrap (bypass), and pending SHALL stay 0.
REQ-015 A second div_load before the apply point SHALL overwrite the shadow; only the last legal value SHALL be applied.
REQ-016 Outside mode updates (REQ-013 to REQ-015), mode SHALL only be sampled at apply points; direct mode changes SHALL be ignored.
REQ-017 N = 2^WIDTH-1 SHALL operate without overflow; the compare SHALL be against N-1 at WIDTH bits.

Reset
REQ-018 While RST_N=0, the block SHALL set p=0, active N=DIV_RESET, shadow N=DIV_RESET, active mode=1, clk_div=0, tick=0, pending=0 and err=0, asynchronously.
REQ-019 Reset assertion mid-period SHALL discard any pending divisor.
REQ-020 After RST_N deasserts, counting SHALL start on the first edge with en=1.

Structure
REQ-021 A shared package SHALL hold the mode encodings (MODE_PULSE=0, MODE_SQUARE=1) and the default DIV_RESET.
REQ-022 The phase counter, with its wrap detect and terminal compare, SHALL be a sub-module named div_phase_counter; shadow/apply logic and output registers SHALL remain at top level.

Verification
REQ-023 Reset, en=1, N=50, square mode -> first tick after edge 50; thereafter clk_div 25 high / 25 low, tick every 50 cycles.
REQ-024 N=7, square mode -> clk_div 3 high / 4 low; N=2 -> clk_div toggles every cycle; N=2, pulse mode -> tick every 2nd cycle.
REQ-025 div_load=10 at p=20 of an N=50 period -> pending=1, current period completes at 50 cycles, next period is 10 cycles, pending clears at the wrap.
REQ-026 div_load=1, then div_load=0 -> err=1, N unchanged, pending=0; a later div_load=8 -> err=0 and N=8 applied at the next wrap.
REQ-027 en low for 13 cycles at p=30 -> p and clk_div frozen, tick=0, period resumes with 20 remaining cycles.
REQ-028 RST_N asserted mid-period with pending=1 -> outputs 0 immediately, pending=0, N=50 after release.
